opt_rand_gen: RTL and testbench
===============================

OPT_RAND_GEN -- requirements
Module: opt_rand_gen

Interface
REQ-001 Parameters SHALL be: CITY_NUM, default 32, tour length (>=4); SEG_MAX, default 3, maximum or-opt segment length (>=1, < CITY_NUM-2); MAX_RETRY, default 64, rejected-draw limit.
REQ-002 clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 seed  in  64  xorshift seed, sampled on an accepted start.
REQ-005 start  in  1  request one move; accepted only in IDLE.
REQ-006 mode  in  2  move type: 0 = THR (pass-through), 1 = OR-opt, 2 = 2-opt; 3 SHALL be treated as 0.
REQ-007 out_ready  in  1  consumer accepts the result.
REQ-008 valid  out  1  result available; held until out_ready.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 com  out  2  move type issued: 0 THR, 1 OR, 2 TWO.
REQ-011 k, l  out  clog2(CITY_NUM) each  move indices.
REQ-012 m  out  clog2(SEG_MAX+1)  segment length; 1 for 2-opt.
REQ-013 r_metropolis, r_exchange  out  32 each  acceptance randoms.
REQ-014 n_seed  out  64  current internal seed, for chaining into the next start.
REQ-015 aborted  out  1  result came from the retry limit (macro only).

Function
REQ-016 States SHALL be IDLE, K, M, L, METRO, EXCH, OUT.
REQ-017 PRNG: x1 = s ^ (s<<13); x2 = x1 ^ (x1>>7); x3 = x2 ^ (x2<<17), 64-bit.
- In each K/M/L/METRO/EXCH cycle the internal seed SHALL update to x3.
- The draw SHALL be x3 ANDed with the state mask.
REQ-018 Masks: K and L SHALL use 2^clog2(CITY_NUM)-1; M SHALL use 2^clog2(SEG_MAX+1)-1; METRO and EXCH SHALL use x3[31:0].
REQ-019 Start in IDLE: the internal seed SHALL load from seed. Mode 0 SHALL go to OUT; modes 1 and 2 SHALL go to K.
REQ-020 K: accept when 1<=draw<=CITY_NUM-1, then go to M (mode 1) or L (mode 2); otherwise stay in K.
REQ-021 M: accept when 1<=draw<=SEG_MAX and k+draw-1<=CITY_NUM-1, then go to L; otherwise return to K.
REQ-022 L: draw<=CITY_NUM-1 is required.
- Mode 2: reject if draw==k or draw+1==k.
- Mode 1: reject if k-1<=draw<=k+m-1.
- Accept goes to METRO; reject goes to K.
REQ-023 METRO SHALL latch r_metropolis and EXCH SHALL latch r_exchange, one cycle each, then go to OUT.
REQ-024 OUT: valid=1, and outputs SHALL be stable. When out_ready=1, the block SHALL go to IDLE and drop valid the next cycle.
REQ-025 Minimum start-to-valid latency SHALL be: mode 0, 1 cycle; mode 2, 5 cycles; mode 1, 6 cycles.
REQ-026 start outside IDLE SHALL be ignored, including in the same cycle as the OUT handshake.
REQ-027 In THR the block SHALL perform no PRNG step, and n_seed SHALL equal the loaded seed.

Reset
REQ-028 Reset SHALL force: state IDLE; valid, busy, aborted = 0; com=THR; k, l, m, r_metropolis, r_exchange = 0; internal seed = 0.
REQ-029 Reset mid-sequence SHALL discard the move, with no valid pulse.

Configuration
REQ-030 Macro OPT_RAND_RETRY_LIMIT_EN, when defined:
- A counter SHALL count rejected draws per request.
- At MAX_RETRY rejections the block SHALL go to OUT with com=THR and aborted=1.
REQ-031 When OPT_RAND_RETRY_LIMIT_EN is undefined: retries SHALL be unbounded, aborted SHALL be tied 0, and seed=0 SHALL be an illegal input.

Verification
REQ-032 CITY_NUM=8, seed=1, mode=2: first K draw SHALL be 0x40822041&7=1, accepted; k=1; n_seed advances one step per draw cycle.
REQ-033 mode=0, seed=0x1234: valid 1 cycle after start; com=THR; n_seed=0x1234.
REQ-034 seed=0, mode=2, macro defined, MAX_RETRY=64: aborted=1 and com=THR after 64 K cycles. Macro undefined: busy stays 1 with no valid.
REQ-035 Hold out_ready=0 for 10 cycles in OUT: valid and all outputs stable. Pulse start meanwhile: ignored.
REQ-036 Assert reset during L: next cycle IDLE, valid=0, busy=0, n_seed=0.
REQ-037 10^5 random seeds, mode 1, SEG_MAX=3: every result satisfies REQ-020 to REQ-022; m covers 1..3; l never lies in [k-1, k+m-1].

Source files
------------

// File: rtl/opt_rand_gen_if.sv
// Request/result bundle for opt_rand_gen; i_/o_ directions are named from the generator's side.
interface opt_rand_gen_if #(
  parameter int unsigned CITY_NUM = 32,
  parameter int unsigned SEG_MAX  = 3
);
  localparam int unsigned KW = $clog2(CITY_NUM);
  localparam int unsigned MW = $clog2(SEG_MAX + 1);

  logic [63:0]   i_seed;
  logic          i_start;
  logic [1:0]    i_mode;
  logic          i_out_ready;
  logic          o_valid;
  logic          o_busy;
  logic [1:0]    o_com;
  logic [KW-1:0] o_k;
  logic [KW-1:0] o_l;
  logic [MW-1:0] o_m;
  logic [31:0]   o_r_metropolis;
  logic [31:0]   o_r_exchange;
  logic [63:0]   o_n_seed;
  logic          o_aborted;

  modport master (
    output i_seed, i_start, i_mode, i_out_ready,
    input  o_valid, o_busy, o_com, o_k, o_l, o_m,
    input  o_r_metropolis, o_r_exchange, o_n_seed, o_aborted
  );

  modport slave (
    input  i_seed, i_start, i_mode, i_out_ready,
    output o_valid, o_busy, o_com, o_k, o_l, o_m,
    output o_r_metropolis, o_r_exchange, o_n_seed, o_aborted
  );
endinterface

// File: rtl/opt_rand_gen.sv
// Or-opt / 2-opt move generator: xorshift64 rejection sampling of (k, m, l) plus two acceptance randoms.
// Optional OPT_RAND_RETRY_LIMIT_EN bounds rejected draws per request and returns an aborted THR result.
module opt_rand_gen #(
  parameter int unsigned CITY_NUM  = 32,
  parameter int unsigned SEG_MAX   = 3,
  parameter int unsigned MAX_RETRY = 64
) (
  input  logic          clk,
  input  logic          reset,
  opt_rand_gen_if.slave bus
);
  localparam int unsigned KW = $clog2(CITY_NUM);
  localparam int unsigned MW = $clog2(SEG_MAX + 1);
  localparam logic [1:0]  COM_THR = 2'd0;
  localparam logic [1:0]  COM_OR  = 2'd1;
  localparam logic [1:0]  COM_TWO = 2'd2;

  if (CITY_NUM < 4 || SEG_MAX < 1 || SEG_MAX + 2 >= CITY_NUM || MAX_RETRY < 1) begin : g_bad_params
    $error("opt_rand_gen: illegal parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_K, S_M, S_L, S_METRO, S_EXCH, S_OUT} state_t;

  state_t        r_state, w_state_nxt;
  logic [63:0]   r_seed, w_seed_nxt;
  logic [KW-1:0] r_k, w_k_nxt, r_l, w_l_nxt;
  logic [MW-1:0] r_m, w_m_nxt;
  logic [31:0]   r_rm, w_rm_nxt, r_rx, w_rx_nxt;
  logic [1:0]    r_com, w_com_nxt;
  logic          r_valid, w_valid_nxt, r_busy, w_busy_nxt;

  // One xorshift64 step from the current internal seed
  logic [63:0] w_x1, w_x2, w_x3;
  assign w_x1 = r_seed ^ (r_seed << 13);
  assign w_x2 = w_x1 ^ (w_x1 >> 7);
  assign w_x3 = w_x2 ^ (w_x2 << 17);

  // Draws and current picks widened so range checks cannot wrap
  logic [31:0] w_kd, w_md, w_k32, w_m32;
  logic        w_k_ok, w_m_ok, w_l_ok;
  assign w_kd  = 32'(w_x3[KW-1:0]);
  assign w_md  = 32'(w_x3[MW-1:0]);
  assign w_k32 = 32'(r_k);
  assign w_m32 = 32'(r_m);

  assign w_k_ok = (w_kd >= 32'd1) && (w_kd <= CITY_NUM - 1);
  assign w_m_ok = (w_md >= 32'd1) && (w_md <= SEG_MAX) && (w_k32 + w_md - 32'd1 <= CITY_NUM - 1);
  // The L draw reuses the K-width bits; 2-opt forbids l in {k-1, k}, or-opt forbids [k-1, k+m-1]
  assign w_l_ok = (w_kd <= CITY_NUM - 1) &&
                  ((r_com == COM_TWO) ? ((w_kd != w_k32) && (w_kd + 32'd1 != w_k32))
                                      : !((w_kd + 32'd1 >= w_k32) && (w_kd <= w_k32 + w_m32 - 32'd1)));

`ifdef OPT_RAND_RETRY_LIMIT_EN
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  logic [RW-1:0] r_retry, w_retry_nxt;
  logic          r_aborted, w_aborted_nxt;
  logic          w_reject;
  assign w_reject = ((r_state == S_K) && !w_k_ok) || ((r_state == S_M) && !w_m_ok) ||
                    ((r_state == S_L) && !w_l_ok);
`endif

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_seed_nxt  = r_seed;
    w_k_nxt     = r_k;
    w_l_nxt     = r_l;
    w_m_nxt     = r_m;
    w_rm_nxt    = r_rm;
    w_rx_nxt    = r_rx;
    w_com_nxt   = r_com;
`ifdef OPT_RAND_RETRY_LIMIT_EN
    w_retry_nxt   = r_retry;
    w_aborted_nxt = r_aborted;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_seed_nxt = bus.i_seed;
          w_k_nxt    = '0;
          w_l_nxt    = '0;
          w_m_nxt    = '0;
          w_rm_nxt   = '0;
          w_rx_nxt   = '0;
`ifdef OPT_RAND_RETRY_LIMIT_EN
          w_retry_nxt   = '0;
          w_aborted_nxt = 1'b0;
`endif
          case (bus.i_mode)
            2'd1: begin
              w_com_nxt   = COM_OR;
              w_state_nxt = S_K;
            end
            2'd2: begin
              w_com_nxt   = COM_TWO;
              w_m_nxt     = MW'(1);
              w_state_nxt = S_K;
            end
            default: begin
              w_com_nxt   = COM_THR;
              w_state_nxt = S_OUT;
            end
          endcase
        end
      end
      S_K: begin
        w_seed_nxt = w_x3;
        if (w_k_ok) begin
          w_k_nxt     = w_x3[KW-1:0];
          w_state_nxt = (r_com == COM_OR) ? S_M : S_L;
        end
      end
      S_M: begin
        w_seed_nxt = w_x3;
        if (w_m_ok) begin
          w_m_nxt     = w_x3[MW-1:0];
          w_state_nxt = S_L;
        end else begin
          w_state_nxt = S_K;
        end
      end
      S_L: begin
        w_seed_nxt = w_x3;
        if (w_l_ok) begin
          w_l_nxt     = w_x3[KW-1:0];
          w_state_nxt = S_METRO;
        end else begin
          w_state_nxt = S_K;
        end
      end
      S_METRO: begin
        w_seed_nxt  = w_x3;
        w_rm_nxt    = w_x3[31:0];
        w_state_nxt = S_EXCH;
      end
      S_EXCH: begin
        w_seed_nxt  = w_x3;
        w_rx_nxt    = w_x3[31:0];
        w_state_nxt = S_OUT;
      end
      S_OUT: begin
        if (bus.i_out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef OPT_RAND_RETRY_LIMIT_EN
    if (w_reject) begin
      w_retry_nxt = r_retry + RW'(1);
      if (32'(r_retry) + 32'd1 >= MAX_RETRY) begin
        w_state_nxt   = S_OUT;
        w_com_nxt     = COM_THR;
        w_aborted_nxt = 1'b1;
      end
    end
`endif
    w_valid_nxt = (w_state_nxt == S_OUT);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_seed  <= '0;
      r_k     <= '0;
      r_l     <= '0;
      r_m     <= '0;
      r_rm    <= '0;
      r_rx    <= '0;
      r_com   <= COM_THR;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
`ifdef OPT_RAND_RETRY_LIMIT_EN
      r_retry   <= '0;
      r_aborted <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_seed  <= w_seed_nxt;
      r_k     <= w_k_nxt;
      r_l     <= w_l_nxt;
      r_m     <= w_m_nxt;
      r_rm    <= w_rm_nxt;
      r_rx    <= w_rx_nxt;
      r_com   <= w_com_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
`ifdef OPT_RAND_RETRY_LIMIT_EN
      r_retry   <= w_retry_nxt;
      r_aborted <= w_aborted_nxt;
`endif
    end
  end

  assign bus.o_valid        = r_valid;
  assign bus.o_busy         = r_busy;
  assign bus.o_com          = r_com;
  assign bus.o_k            = r_k;
  assign bus.o_l            = r_l;
  assign bus.o_m            = r_m;
  assign bus.o_r_metropolis = r_rm;
  assign bus.o_r_exchange   = r_rx;
  assign bus.o_n_seed       = r_seed;
`ifdef OPT_RAND_RETRY_LIMIT_EN
  assign bus.o_aborted      = r_aborted;
`else
  assign bus.o_aborted      = 1'b0;
`endif
endmodule

// File: tb/tb_opt_rand_gen.sv
// Bench for opt_rand_gen: rejection-sampling reference model, per-cycle compare process, directed moves.
// Honours OPT_RAND_RETRY_LIMIT_EN for the seed=0 case.
module tb_opt_rand_gen;
  localparam int unsigned CITY_NUM  = 8;
  localparam int unsigned SEG_MAX   = 3;
  localparam int unsigned MAX_RETRY = 64;
  localparam int unsigned KW        = $clog2(CITY_NUM);
  localparam int unsigned MW        = $clog2(SEG_MAX + 1);
  localparam int          LIMIT     = 400;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  opt_rand_gen_if #(.CITY_NUM(CITY_NUM), .SEG_MAX(SEG_MAX)) bus ();
  opt_rand_gen #(.CITY_NUM(CITY_NUM), .SEG_MAX(SEG_MAX), .MAX_RETRY(MAX_RETRY)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [1:0]  com;
    logic [31:0] k;
    logic [31:0] l;
    logic [31:0] m;
    logic [31:0] rm;
    logic [31:0] rx;
    logic [63:0] nseed;
    logic [31:0] lat;
    logic        aborted;
    logic        hang;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_cur;
  bit   exp_on = 1'b0;
  int   m_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] step(input logic [63:0] s);
    logic [63:0] x;
    x = s ^ (s << 13);
    x = x ^ (x >> 7);
    x = x ^ (x << 17);
    return x;
  endfunction

  // Any rejected draw restarts from a fresh k; one PRNG step per draw, METRO/EXCH add two more.
  function automatic exp_t model(input logic [63:0] seed, input logic [1:0] mode);
    exp_t        e;
    logic [63:0] s;
    int          cyc, rej, k, m, l;
    e = '0;
    s = seed;
    cyc = 0;
    rej = 0;
    e.com = (mode == 2'd1 || mode == 2'd2) ? mode : 2'd0;
    if (e.com == 2'd0) begin
      e.nseed = seed;
      e.lat   = 32'd1;
      return e;
    end
    forever begin
      if (cyc + 4 >= LIMIT) begin
        e.hang = 1'b1;
        return e;
      end
`ifdef OPT_RAND_RETRY_LIMIT_EN
      if (rej == int'(MAX_RETRY)) begin
        e.aborted = 1'b1;
        e.com     = 2'd0;
        e.nseed   = s;
        e.lat     = 32'(cyc + 1);
        return e;
      end
`endif
      s = step(s); cyc++; k = int'(s[KW-1:0]);
      if (k < 1 || k > int'(CITY_NUM) - 1) begin rej++; continue; end
      if (mode == 2'd1) begin
        s = step(s); cyc++; m = int'(s[MW-1:0]);
        if (m < 1 || m > int'(SEG_MAX) || k + m - 1 > int'(CITY_NUM) - 1) begin rej++; continue; end
      end else begin
        m = 1;
      end
      s = step(s); cyc++; l = int'(s[KW-1:0]);
      if (l > int'(CITY_NUM) - 1) begin rej++; continue; end
      if (mode == 2'd2 ? (l == k || l + 1 == k) : (l >= k - 1 && l <= k + m - 1)) begin rej++; continue; end
      break;
    end
    s = step(s); e.rm = s[31:0];
    s = step(s); e.rx = s[31:0];
    e.k = 32'(k); e.l = 32'(l); e.m = 32'(m);
    e.nseed = s;
    e.lat   = 32'(cyc + 3);
    return e;
  endfunction

  // Every cycle a move is outstanding: busy while running, full result while valid
  always @(negedge clk) begin
    if (exp_on) begin
      check("busy", bus.o_busy, 1);
      if (bus.o_valid) begin
        check("com", bus.o_com, exp_cur.com);
        check("aborted", bus.o_aborted, exp_cur.aborted);
        check("n_seed", bus.o_n_seed, exp_cur.nseed);
        if (!exp_cur.aborted) begin
          check("k", bus.o_k, exp_cur.k);
          check("l", bus.o_l, exp_cur.l);
          check("m", bus.o_m, exp_cur.m);
          check("r_metropolis", bus.o_r_metropolis, exp_cur.rm);
          check("r_exchange", bus.o_r_exchange, exp_cur.rx);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic run_move(input logic [63:0] seed, input logic [1:0] mode, input int hold, input bit poke);
    exp_t e;
    int   cyc;
    int   k, l, m;
    e = model(seed, mode);
    @(negedge clk); bus.i_seed = seed; bus.i_mode = mode; bus.i_start = 1'b1;
    @(posedge clk); exp_cur = e; exp_on = 1'b1;
    @(negedge clk); bus.i_start = 1'b0; cyc = 1;
    while (!bus.o_valid && cyc < LIMIT) begin @(negedge clk); cyc++; end
    if (e.hang || !bus.o_valid) begin
      if (e.hang) check("no_valid_while_stuck", bus.o_valid, 0);
      else        check("valid_timeout", 0, 1);
      exp_on = 1'b0;
      do_reset();
      return;
    end
    check("latency", 64'(cyc), 64'(e.lat));
    if (e.com == 2'd1 && !e.aborted) begin
      k = int'(bus.o_k); l = int'(bus.o_l); m = int'(bus.o_m);
      check("or_m_range", 64'(m >= 1 && m <= int'(SEG_MAX) && k + m - 1 <= int'(CITY_NUM) - 1), 1);
      check("or_l_outside", 64'(!(l >= k - 1 && l <= k + m - 1)), 1);
      m_seen = m_seen | (1 << m);
    end
    for (int i = 0; i < hold; i++) begin
      bus.i_start = poke && (i == hold / 2);
      bus.i_seed  = ~seed;
      bus.i_mode  = 2'd1;
      @(negedge clk);
    end
    bus.i_start = poke; bus.i_mode = 2'd2; bus.i_out_ready = 1'b1;
    @(posedge clk); exp_on = 1'b0;
    @(negedge clk); bus.i_start = 1'b0; bus.i_out_ready = 1'b0;
    check("valid_drop", bus.o_valid, 0);
    check("idle_busy", bus.o_busy, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    exp_t        e0;
    logic [63:0] s;
    int          seen_valid;
    bus.i_seed = '0; bus.i_start = 1'b0; bus.i_mode = 2'd0; bus.i_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.o_valid, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_com", bus.o_com, 0);
    check("rst_k", bus.o_k, 0);
    check("rst_l", bus.o_l, 0);
    check("rst_m", bus.o_m, 0);
    check("rst_rm", bus.o_r_metropolis, 0);
    check("rst_rx", bus.o_r_exchange, 0);
    check("rst_n_seed", bus.o_n_seed, 0);
    check("rst_aborted", bus.o_aborted, 0);
    reset = 1'b0;

    // Hand-derived pins on the reference model
    check("model_step_1", step(64'd1), 64'h4082_2041);
    e0 = model(64'h1234, 2'd0);
    check("model_thr_lat", 64'(e0.lat), 1);
    check("model_thr_seed", e0.nseed, 64'h1234);
    e0 = model(64'd1, 2'd2);
    check("model_two_minlat", 64'(e0.lat >= 5), 1);

    // First 2-opt draw from seed 1 is k=1; reset while in L discards the move
    @(negedge clk); bus.i_seed = 64'd1; bus.i_mode = 2'd2; bus.i_start = 1'b1;
    @(negedge clk); bus.i_start = 1'b0;
    check("seed_loaded", bus.o_n_seed, 64'd1);
    check("busy_after_start", bus.o_busy, 1);
    @(negedge clk);
    check("k_first_draw", bus.o_k, 1);
    check("n_seed_one_step", bus.o_n_seed, 64'h4082_2041);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("rstL_valid", bus.o_valid, 0);
    check("rstL_busy", bus.o_busy, 0);
    check("rstL_n_seed", bus.o_n_seed, 0);
    seen_valid = 0;
    repeat (8) begin @(negedge clk); seen_valid = seen_valid | int'(bus.o_valid); end
    check("rstL_no_valid", 64'(seen_valid), 0);

    // Directed moves: THR with held OUT and stray starts, 2-opt, or-opt, mode 3
    run_move(64'h1234, 2'd0, 10, 1'b1);
    check("thr_literal_seed", bus.o_n_seed, 64'h1234);
    run_move(64'd1, 2'd2, 10, 1'b1);
    run_move(64'hDEAD_BEEF_CAFE_F00D, 2'd1, 3, 1'b1);
    run_move(64'h0BAD_5EED_0000_0001, 2'd3, 2, 1'b0);

    for (int i = 0; i < 60; i++) begin
      s = {$urandom, $urandom} | 64'd1;
      run_move(s, 2'd1, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 20; i++) begin
      s = {$urandom, $urandom} | 64'd1;
      run_move(s, 2'd2, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    check("or_m_coverage", 64'(m_seen & 32'he), 64'he);

    // Zero seed: aborted THR after the retry limit, or stuck busy without the limit
    run_move(64'd0, 2'd2, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
